// File: rtl/clock_enable_gen_pkg.sv
// Shared types and default parameters for the clock-enable generator.
package clock_enable_gen_pkg;

  // Default block parameters.
  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_ACC_WIDTH    = 32;
  localparam int DEF_LOCK_CYCLES  = 1024;

  // Width of the channel-select field on the configuration port.
  localparam int CFG_CH_W = 3;

  // Lock supervisor states.
  typedef enum logic [1:0] {
    LOCK_IDLE   = 2'd0,
    LOCK_SETTLE = 2'd1,
    LOCK_LOCKED = 2'd2
  } lock_state_e;

endpackage : clock_enable_gen_pkg

// File: rtl/clock_enable_gen_nco.sv
// One numerically controlled oscillator channel: a phase accumulator whose
// carry-out is the clock-enable pulse and whose MSB is the square-wave output.
module clock_enable_gen_nco
  import clock_enable_gen_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 wr,        // load incr/phase/acc for this channel
  input  logic                 sync,      // realign acc to the stored phase
  input  logic [ACC_WIDTH-1:0] incr_in,
  input  logic [ACC_WIDTH-1:0] phase_in,
  output logic                 ce,
  output logic                 outclk
);

  logic [ACC_WIDTH-1:0] incr_q, incr_d;
  logic [ACC_WIDTH-1:0] phase_q, phase_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ce_q, ce_d;
  logic [ACC_WIDTH:0]   sum;

  // Extra top bit captures the carry-out of the accumulator addition.
  assign sum = {1'b0, acc_q} + {1'b0, incr_q};

  // Next-state: a write beats sync (the new phase wins), sync beats counting,
  // and a zero increment freezes the accumulator.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    incr_d  = incr_q;
    phase_d = phase_q;
    acc_d   = acc_q;
    ce_d    = 1'b0;
    if (wr) begin
      incr_d  = incr_in;
      phase_d = phase_in;
      acc_d   = phase_in;
    end else if (sync) begin
      acc_d = phase_q;
    end else if (incr_q != '0) begin
      acc_d = sum[ACC_WIDTH-1:0];
      ce_d  = sum[ACC_WIDTH];
    end
  end

  // Channel state registers.
  always_ff @(posedge refclk or posedge rst) begin
    // NOTE: these are a handful of control registers, not a memory array,
    // so all of them take the asynchronous reset to a known zero state.
    if (rst) begin
      incr_q  <= '0;
      phase_q <= '0;
      acc_q   <= '0;
      ce_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      incr_q  <= incr_d;
      phase_q <= phase_d;
      acc_q   <= acc_d;
      ce_q    <= ce_d;
    end
  end

  assign ce     = ce_q;
  assign outclk = acc_q[ACC_WIDTH-1];

endmodule : clock_enable_gen_nco

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: NUM_CHANNELS independent NCOs sharing
// one configuration port, plus a lock supervisor that reports when channel
// settings have been stable for LOCK_CYCLES cycles.
module clock_enable_gen
  import clock_enable_gen_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
  parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    cfg_wr,
  input  logic [CFG_CH_W-1:0]     cfg_ch,
  input  logic [ACC_WIDTH-1:0]    cfg_incr,
  input  logic [ACC_WIDTH-1:0]    cfg_phase,
  input  logic                    cfg_sync,
  output logic [NUM_CHANNELS-1:0] ce,
  output logic [NUM_CHANNELS-1:0] outclk,
  output logic                    locked
);

  localparam int                 CNT_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [CFG_CH_W:0]  NUM_CH_X = (CFG_CH_W + 1)'(NUM_CHANNELS);

  // A write to a channel that does not exist is dropped everywhere.
  logic cfg_valid;
  assign cfg_valid = cfg_wr && ({1'b0, cfg_ch} < NUM_CH_X);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic ch_wr;
    assign ch_wr = cfg_valid && (cfg_ch == CFG_CH_W'(i));

    clock_enable_gen_nco #(
      .ACC_WIDTH (ACC_WIDTH)
    ) u_nco (
      .refclk   (refclk),
      .rst      (rst),
      .wr       (ch_wr),
      .sync     (cfg_sync),
      .incr_in  (cfg_incr),
      .phase_in (cfg_phase),
      .ce       (ce[i]),
      .outclk   (outclk[i])
    );
  end

  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d;

  // Lock supervisor next-state: settle for LOCK_CYCLES cycles after reset or
  // after any accepted configuration write; sync pulses do not disturb lock.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOCK_IDLE: begin
        state_d = LOCK_SETTLE;
        cnt_d   = '0;
      end
      LOCK_SETTLE: begin
        if (cnt_q >= CNT_LAST) begin
          state_d = LOCK_LOCKED;
        end else if (cnt_q != CNT_MAX) begin
          // Saturating count: it can never wrap back to zero.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOCK_LOCKED: state_d = LOCK_LOCKED;
      default:     state_d = LOCK_IDLE;
    endcase
    if (cfg_valid) begin
      state_d = LOCK_SETTLE;
      cnt_d   = '0;
    end
    locked_d = (state_d == LOCK_LOCKED);
  end

  // Lock supervisor registers; locked is its own flop so it is glitch-free.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q  <= LOCK_IDLE;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule : clock_enable_gen

// File: tb/tb_clock_enable_gen.sv
// Directed self-checking bench for clock_enable_gen (default parameters).
module tb_clock_enable_gen;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int LC  = 1024;

  logic           refclk    = 1'b0;
  logic           rst       = 1'b1;
  logic           cfg_wr    = 1'b0;
  logic [2:0]     cfg_ch    = '0;
  logic [AW-1:0]  cfg_incr  = '0;
  logic [AW-1:0]  cfg_phase = '0;
  logic           cfg_sync  = 1'b0;
  logic [NCH-1:0] ce;
  logic [NCH-1:0] outclk;
  logic           locked;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  clock_enable_gen #(
    .NUM_CHANNELS (NCH),
    .ACC_WIDTH    (AW),
    .LOCK_CYCLES  (LC)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_incr  (cfg_incr),
    .cfg_phase (cfg_phase),
    .cfg_sync  (cfg_sync),
    .ce        (ce),
    .outclk    (outclk),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled and inputs
  // changed 1 ns later.
  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [AW-1:0] incr,
                           input logic [AW-1:0] phase, input logic sync);
    cfg_wr    = 1'b1;
    cfg_ch    = ch;
    cfg_incr  = incr;
    cfg_phase = phase;
    cfg_sync  = sync;
    tick();
    cfg_wr    = 1'b0;
    cfg_sync  = 1'b0;
  endtask

  initial begin
    int          first;
    int          bad_cnt;
    int          guard;
    int          s_cyc;
    int          b_cyc;
    int          d;
    logic [15:0] h1;
    logic [15:0] h2;
    logic [3:0]  e;

    // Reset values, then 1100 idle cycles.
    repeat (3) tick();
    check("rst_ce", ce, 0);
    check("rst_outclk", outclk, 0);
    check("rst_locked", locked, 0);
    rst     = 1'b0;
    first   = 0;
    bad_cnt = 0;
    for (int k = 1; k <= 1100; k++) begin
      tick();
      if (k == 1) check("release_quiet", {ce, outclk, locked}, 0);
      if (locked === 1'b1 && first == 0) first = k;
      if (ce !== '0 || outclk !== '0) bad_cnt++;
    end
    check("lock_after_reset", first, LC + 1);
    check("idle_ce_outclk", bad_cnt, 0);

    // Channel 0 at half rate.
    cfg_write(3'd0, 32'h8000_0000, 32'h0, 1'b0);
    check("wr_ch0_ce_low", ce[0], 0);
    check("wr_drops_lock", locked, 0);
    h1 = '0;
    h2 = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      h1[k-1] = ce[0];
      h2[k-1] = outclk[0];
    end
    check("ch0_ce_pattern", h1[7:0], 8'hAA);
    check("ch0_outclk_pattern", h2[7:0], 8'h55);

    // Channels 1 and 2 at quarter rate, half a period apart after sync.
    cfg_write(3'd1, 32'h4000_0000, 32'h0, 1'b0);
    cfg_write(3'd2, 32'h4000_0000, 32'h8000_0000, 1'b0);
    b_cyc = cyc;
    tick();
    cfg_sync = 1'b1;
    tick();
    cfg_sync = 1'b0;
    s_cyc = cyc;
    check("sync_ce_low", ce, 0);
    h1 = '0;
    h2 = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      h1[k-1] = ce[1];
      h2[k-1] = ce[2];
    end
    check("ch1_ce_pattern", h1[11:0], 12'h888);
    check("ch2_ce_pattern", h2[11:0], 12'h222);

    // Sync does not disturb lock: lock follows the last valid write.
    guard = 0;
    while (locked !== 1'b1 && guard < 1500) begin
      tick();
      guard++;
    end
    check("relock_time", cyc - b_cyc, LC);

    // Writes to nonexistent channels are ignored.
    cfg_write(3'd5, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    check("bad_ch5_locked", locked, 1);
    cfg_write(3'd4, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    check("bad_ch4_locked", locked, 1);
    bad_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      d = cyc - s_cyc;
      e = {1'b0, (d % 4 == 2), (d % 4 == 0), (d % 2 == 0)};
      if (ce !== e || locked !== 1'b1) bad_cnt++;
    end
    check("bad_ch_no_effect", bad_cnt, 0);

    // Simultaneous write and sync: the written channel takes the new phase.
    cfg_write(3'd2, 32'h4000_0000, 32'h0, 1'b1);
    h1 = '0;
    h2 = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      h1[k-1] = ce[1];
      h2[k-1] = ce[2];
    end
    check("wr_sync_ch1", h1[7:0], 8'h88);
    check("wr_sync_ch2", h2[7:0], 8'h88);

    // Channel 3 runs, then is frozen with a zero increment.
    cfg_write(3'd3, 32'h2000_0000, 32'h0, 1'b0);
    h1 = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      h1[k-1] = ce[3];
    end
    check("ch3_run_ce", h1[7:0], 8'h80);
    cfg_write(3'd3, 32'h0, 32'hC000_0000, 1'b0);
    check("ch3_frozen_load", outclk[3], 1);
    bad_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ce[3] !== 1'b0 || outclk[3] !== 1'b1) bad_cnt++;
    end
    check("ch3_frozen_hold", bad_cnt, 0);

    // A valid write at settle count 500 restarts the count.
    cfg_write(3'd0, 32'h8000_0000, 32'h0, 1'b0);
    repeat (500) tick();
    check("settle_500_unlocked", locked, 0);
    cfg_write(3'd0, 32'h8000_0000, 32'h0, 1'b0);
    first = 0;
    for (int k = 1; k <= LC + 5; k++) begin
      tick();
      if (locked === 1'b1 && first == 0) first = k;
    end
    check("lock_after_restart", first, LC);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ce", ce, 0);
    check("async_rst_outclk", outclk, 0);
    check("async_rst_locked", locked, 0);
    #9;
    rst     = 1'b0;
    first   = 0;
    bad_cnt = 0;
    for (int k = 1; k <= LC + 5; k++) begin
      tick();
      if (locked === 1'b1 && first == 0) first = k;
      if (ce !== '0 || outclk !== '0) bad_cnt++;
    end
    check("lock_after_mid_rst", first, LC + 1);
    check("mid_rst_quiet", bad_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_clock_enable_gen

// File: doc/clock_enable_gen.md
CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

Interface
REQ-001 Parameter NUM_CHANNELS, default 4, number of independent output channels (legal 1..8).
REQ-002 Parameter ACC_WIDTH, default 32, phase-accumulator width in bits (legal 8..48).
REQ-003 Parameter LOCK_CYCLES, default 1024, settle cycles before locked asserts (legal 1..65535).
REQ-004 refclk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cfg_wr  input  1  one-cycle configuration write strobe.
REQ-007 cfg_ch  input  3  target channel index for cfg_wr.
REQ-008 cfg_incr  input  ACC_WIDTH  frequency increment for the target channel.
REQ-009 cfg_phase  input  ACC_WIDTH  accumulator load (phase offset) for the target channel.
REQ-010 cfg_sync  input  1  one-cycle strobe that realigns all channels.
REQ-011 ce  output  NUM_CHANNELS  per-channel one-cycle clock-enable pulses.
REQ-012 outclk  output  NUM_CHANNELS  per-channel approximately-50%-duty square wave.
REQ-013 locked  output  1  all channel settings stable for LOCK_CYCLES cycles.

Function
REQ-014 Each channel SHALL hold registers incr[i], phase[i] and acc[i], each ACC_WIDTH bits wide.
REQ-015 Each cycle with incr[i] nonzero: acc[i] <= (acc[i] + incr[i]) mod 2^ACC_WIDTH.
- ce[i] <= carry-out of that addition.
- ce[i] is high for exactly the cycle in which acc[i] holds a wrapped value.
REQ-016 outclk[i] SHALL equal the registered MSB of acc[i].
- Output frequency = f_refclk * incr[i] / 2^ACC_WIDTH.
REQ-017 incr[i] == 0 SHALL freeze acc[i], hold outclk[i] and keep ce[i] low.
REQ-018 A cfg_wr sampled at edge E with cfg_ch < NUM_CHANNELS SHALL, at E:
- load incr[cfg_ch] and phase[cfg_ch];
- set acc[cfg_ch] <= cfg_phase;
- drive ce[cfg_ch] low for that cycle.
REQ-019 A cfg_wr with cfg_ch >= NUM_CHANNELS SHALL be ignored entirely, with no effect on the lock state.
REQ-020 cfg_sync at edge E SHALL set every acc[i] <= phase[i] and drive every ce low for that cycle.
REQ-021 If cfg_wr and cfg_sync occur in the same cycle, cfg_sync SHALL apply to all channels and the cfg_wr SHALL apply to its target channel, with the new cfg_phase taking priority.
REQ-022 The lock FSM SHALL have states IDLE, SETTLE and LOCKED.
- IDLE -> SETTLE on the first cycle after reset deassertion.
- SETTLE counts LOCK_CYCLES cycles, then -> LOCKED.
- A valid cfg_wr in SETTLE or LOCKED -> SETTLE with the counter cleared.
- cfg_sync does not affect lock.
REQ-023 locked SHALL be registered and high only in LOCKED.
- locked deasserts in the cycle after the edge that samples a valid cfg_wr.
REQ-024 The settle counter SHALL saturate and never wrap.

Reset
REQ-025 While rst is high, all outputs SHALL be held at their reset values:
- ce = 0, outclk = 0, locked = 0;
- all acc, incr and phase = 0;
- FSM = IDLE, counter = 0.
REQ-026 Reset asserted mid-operation SHALL take effect immediately (asynchronously). Release SHALL be sampled synchronously; no output toggles in the first cycle after release.

Structure
REQ-027 Package clock_enable_gen_pkg SHALL hold:
- the lock FSM state enum;
- the default NUM_CHANNELS, ACC_WIDTH and LOCK_CYCLES values;
- the cfg_ch width constant.
REQ-028 The per-channel accumulator SHALL be the sub-module clock_enable_gen_nco, instantiated NUM_CHANNELS times; the lock FSM stays in the top level.

Verification
REQ-029 Reset, then 1100 idle cycles -> locked rises exactly LOCK_CYCLES+1 cycles after rst falls; ce and outclk stay 0.
REQ-030 Write ch0 incr=0x8000_0000, phase=0 -> ce[0] high on every second cycle starting 2 cycles after the write; outclk[0] toggles every cycle.
REQ-031 Write ch1 incr=0x4000_0000, then write ch2 incr=0x4000_0000, phase=0x8000_0000, then pulse cfg_sync -> ch1 and ch2 each pulse ce every 4 cycles, offset by exactly 2 cycles.
REQ-032 Write to ch 5 with NUM_CHANNELS=4 while locked -> no state change and locked stays 1. Write to ch 0 at lock count 500 -> counter restarts and locked rises LOCK_CYCLES cycles later.
REQ-033 Write ch3 incr=0 mid-run -> ce[3] stays 0 and outclk[3] holds its loaded-phase MSB.
REQ-034 Assert rst mid-run for 1 cycle between clock edges -> all outputs are 0 before the next edge, and the lock sequence restarts.
